// File: rtl/seq_alu_pkg.sv
// Shared opcode map and FSM state type for the sequential ALU.
package seq_alu_pkg;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SLLI  = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_BEQ   = 4'd5;
  localparam logic [3:0] OP_SUB   = 4'd6;
  localparam logic [3:0] OP_BGE   = 4'd7;
  localparam logic [3:0] OP_MULHU = 4'd8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    DONE     = 2'd2
  } state_t;

endpackage

// File: rtl/seq_alu_mul_iter.sv
// Shift-add multiplier, one multiplier bit per clock; PW sets the retained product width.
// done/prod describe the iteration committed on the current edge, so the caller can latch it directly.
module seq_alu_mul_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned PW    = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [PW-1:0]    prod
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic [PW-1:0]    w_acc_next;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign busy       = r_busy;
  assign done       = r_busy && (r_cnt == '0);
  assign prod       = w_acc_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (start) begin
      r_acc    <= '0;
      r_mcand  <= PW'(a);
      r_mplier <= b;
      r_cnt    <= CW'(WIDTH - 1);
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (r_cnt == '0) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle ops register in one cycle, multiply iterates WIDTH cycles.
// Define SEQ_ALU_MULH_EN to enable opcode 8 (mulhu, upper product half).
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

`ifdef SEQ_ALU_MULH_EN
  localparam int unsigned PW = 2 * WIDTH;
`else
  localparam int unsigned PW = WIDTH;
`endif

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             w_accept;
  logic             w_is_mul;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_zero;
  logic [WIDTH-1:0] w_mul_res;
  logic             w_mul_busy;
  logic             w_mul_done;
  logic [PW-1:0]    w_prod;
`ifdef SEQ_ALU_MULH_EN
  logic             r_hi;
`endif

  // Combinational on out_ready so a new op can issue in the cycle the result drains.
  assign in_ready  = ((r_state == IDLE) || ((r_state == DONE) && out_ready)) && !w_mul_busy;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign zero      = r_zero;

`ifdef SEQ_ALU_MULH_EN
  assign w_is_mul  = (ALU_control == OP_MULT) || (ALU_control == OP_MULHU);
  assign w_mul_res = r_hi ? w_prod[PW-1:WIDTH] : w_prod[WIDTH-1:0];
`else
  assign w_is_mul  = (ALU_control == OP_MULT);
  assign w_mul_res = w_prod;
`endif

  seq_alu_mul_iter #(
    .WIDTH(WIDTH),
    .PW   (PW)
  ) u_mul (
    .clk  (clk),
    .rst_n(rst_n),
    .start(w_accept && w_is_mul),
    .a    (A),
    .b    (B),
    .busy (w_mul_busy),
    .done (w_mul_done),
    .prod (w_prod)
  );

  always_comb begin
    w_alu_res  = '0;
    w_alu_zero = 1'b0;
    case (ALU_control)
      OP_ADD:  w_alu_res  = A + B;
      OP_SUB:  w_alu_res  = A - B;
      OP_XOR:  w_alu_res  = A ^ B;
      OP_SLLI: w_alu_res  = A << B[SHW-1:0];
      OP_BGE:  w_alu_zero = (A >= B);
      OP_BEQ:  w_alu_zero = (A == B);
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next = w_is_mul ? MUL_BUSY : DONE;
      end
      MUL_BUSY: begin
        if (w_mul_done) w_next = DONE;
      end
      DONE: begin
        if (out_ready) begin
          if (w_accept) w_next = w_is_mul ? MUL_BUSY : DONE;
          else          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_result <= '0;
      r_zero   <= 1'b0;
`ifdef SEQ_ALU_MULH_EN
      r_hi     <= 1'b0;
`endif
    end else if (w_accept && !w_is_mul) begin
      r_result <= w_alu_res;
      r_zero   <= w_alu_zero;
`ifdef SEQ_ALU_MULH_EN
    end else if (w_accept) begin
      r_hi     <= (ALU_control == OP_MULHU);
`endif
    end else if ((r_state == MUL_BUSY) && w_mul_done) begin
      r_result <= w_mul_res;
      r_zero   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed latency/boundary cases plus randomized traffic.
module tb_seq_alu;
  import seq_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [3:0]  ALU_control = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;

  int          checks = 0;
  int          failures = 0;
  logic [32:0] exp_q[$];
  logic [32:0] mon_e;
  bit          rnd = 1'b0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .ALU_control(ALU_control),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero)
  );

  // Reference: {result, zero} straight from the opcode definitions.
  function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      4'd2: begin r = a + b; return {r, 1'b0}; end
      4'd6: begin r = a - b; return {r, 1'b0}; end
      4'd4: return {a ^ b, 1'b0};
      4'd3: begin r = a * (32'd1 << (b % 32)); return {r, 1'b0}; end
      4'd1: return {p[31:0], 1'b0};
      4'd7: return {32'd0, a >= b};
      4'd5: return {32'd0, a == b};
`ifdef SEQ_ALU_MULH_EN
      4'd8: return {p[63:32], 1'b0};
`endif
      default: return 33'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] op);
`ifdef SEQ_ALU_MULH_EN
    if (op == 4'd8) return 33;
`endif
    return (op == 4'd1) ? 33 : 1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare on every output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got result=0x%0h zero=%0b expected no output", result, zero);
      end else begin
        mon_e = exp_q.pop_front();
        check("scoreboard", {31'd0, result, zero}, {31'd0, mon_e});
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int  g;
    bit  acc;
    ALU_control = op;
    A = a;
    B = b;
    in_valid = 1'b1;
    exp_q.push_back(model(op, a, b));
    g = 0;
    acc = 1'b0;
    while (!acc && g < 200) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      else begin
        g++;
        @(posedge clk);
        #1;
        if (rnd) out_ready = 1'($urandom_range(0, 1));
      end
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got in_ready=0 for 200 cycles expected 1");
      void'(exp_q.pop_back());
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = $urandom;
    B = $urandom;
    ALU_control = 4'($urandom);
    if (rnd) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic issue_lat(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int lat;
    bit rdy_bad;
    out_ready = 1'b1;
    issue(op, a, b);
    lat = 0;
    rdy_bad = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
      if (in_ready) rdy_bad = 1'b1;
    end
    check({name, "_latency"}, 64'(lat), 64'(model_lat(op)));
    if (model_lat(op) > 1) check({name, "_in_ready_busy"}, 64'(rdy_bad), 64'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 3))
      0: return 32'($urandom_range(0, 7));
      1: return 32'hFFFF_FFFF - 32'($urandom_range(0, 7));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [3:0]  rop;
    int          g;

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_zero", 64'(zero), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;

    // Abort a multiply with reset on its tenth iteration edge.
    out_ready = 1'b1;
    issue(OP_MULT, 32'd5, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("abort_no_late_output", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    issue_lat("add_after_abort", OP_ADD, 32'd1, 32'd1);

    issue_lat("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'd1);
    issue_lat("sub_neg", OP_SUB, 32'd3, 32'd5);
    issue_lat("mult_1e16", OP_MULT, 32'h0001_0000, 32'h0001_0000);
    issue_lat("mult_max2", OP_MULT, 32'hFFFF_FFFF, 32'd2);
    issue_lat("op8", OP_MULHU, 32'h0001_0000, 32'h0001_0000);
    issue_lat("bge_lt", OP_BGE, 32'd3, 32'd5);
    issue_lat("bge_eq", OP_BGE, 32'd5, 32'd5);
    issue_lat("bge_unsigned", OP_BGE, 32'hFFFF_FFFF, 32'd1);
    issue_lat("beq_eq", OP_BEQ, 32'd7, 32'd7);
    issue_lat("beq_ne", OP_BEQ, 32'd7, 32'd8);
    issue_lat("slli_31", OP_SLLI, 32'd1, 32'd31);
    issue_lat("slli_33", OP_SLLI, 32'd1, 32'd33);
    issue_lat("op15", 4'd15, 32'h1234_5678, 32'h1234_5678);

    // Backpressure hold, then simultaneous drain and issue.
    out_ready = 1'b0;
    issue(OP_ADD, 32'd5, 32'd6);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_result_hold", 64'(result), 64'd11);
      check("bp_out_valid_hold", 64'(out_valid), 64'd1);
      check("bp_in_ready_low", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    ALU_control = OP_XOR;
    A = 32'hF0;
    B = 32'hFF;
    in_valid = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back(model(OP_XOR, 32'hF0, 32'hFF));
    @(negedge clk);
    check("bp_both_fire", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_next_valid", 64'(out_valid), 64'd1);
    check("bp_next_result", 64'(result), 64'h0F);
    @(posedge clk);
    #1;

    // Randomized traffic with random consumer stalls.
    rnd = 1'b1;
    for (int n = 0; n < 60; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra = rand_operand();
      rb = ($urandom_range(0, 3) == 0) ? ra : rand_operand();
      issue(rop, ra, rb);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
        out_ready = 1'($urandom_range(0, 1));
      end
    end
    rnd = 1'b0;
    out_ready = 1'b1;
    g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(posedge clk);
      g++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked successor to the single-cycle combinational ALU. It keeps the same ALU_control opcode map and adds a variable shift amount.
- Multiply becomes an iterative shift-add engine at one bit per cycle. All other ops finish in one registered cycle.
- Sits between decode/register-read and writeback in the multi-cycle datapath. Stalls upstream via in_ready and holds results under downstream backpressure.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 2.
- SHW, $clog2(WIDTH), width of the shift-amount field taken from B[SHW-1:0].

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  operation request valid
- in_ready  output  1  block can accept a request this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B (shift amount in B[SHW-1:0] for slli)
- ALU_control  input  4  opcode
- out_valid  output  1  result/zero valid
- out_ready  input  1  consumer takes the result this cycle
- result  output  WIDTH  registered result
- zero  output  1  registered branch-taken flag

Behaviour:
- One clock. Reset is synchronous and active-low: it is sampled only on the rising edge of clk while rst_n=0.
- Reset values:
  - state=IDLE
  - out_valid=0, result=0, zero=0
  - internal accumulator, multiplicand and bit counter all 0
- Reset mid-multiply aborts the operation; no output is produced.
- Opcodes:
  - 2 add: A+B, wraps mod 2^WIDTH
  - 6 sub: A-B, wraps
  - 4 xor: A^B
  - 3 slli: A << B[SHW-1:0]
  - 1 mult: low WIDTH bits of the unsigned product
  - 7 bge: zero = (A >= B), unsigned compare; result=0
  - 5 beq: zero = (A == B); result=0
  - any other code: result=0, zero=0, one-cycle latency
- zero is 0 for every non-branch op.
- Accept event: in_valid && in_ready at a rising edge (call this edge E0). Operands are captured at E0; later input changes are ignored.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This is combinational on out_ready and allows a back-to-back issue in the same cycle the result is consumed.
- States:
  - IDLE --accept single-cycle op--> DONE
  - IDLE --accept mult--> MUL_BUSY
  - MUL_BUSY --after WIDTH iterations--> DONE
  - DONE --out_ready && !accept--> IDLE
  - DONE --out_ready && accept--> DONE or MUL_BUSY, according to the new op
  - DONE --!out_ready--> DONE, with result and zero held stable
- Latency:
  - Single-cycle ops: out_valid=1 in the cycle after E0.
  - mult: one iteration on each edge E1..E_WIDTH; out_valid=1 in the cycle after E_WIDTH.
  - in_ready=0 throughout MUL_BUSY.
- Multiply iteration: when multiplier LSB=1, add the multiplicand into a 2·WIDTH accumulator; then shift the multiplicand left and the multiplier right. The counter runs WIDTH-1 down to 0.
- out_valid falls on the edge where out_ready=1 and no new accept occurs. On the same edge as a new accept of a single-cycle op, out_valid stays 1 and result updates.

Optional Feature:
- Macro: SEQ_ALU_MULH_EN.
- Defined: opcode 8 (mulhu) runs the same WIDTH-cycle engine and returns product bits [2·WIDTH-1:WIDTH]. The full 2·WIDTH accumulator is retained.
- Undefined: opcode 8 is treated as unsupported (result 0, one-cycle latency). The accumulator may be trimmed to the low WIDTH bits plus carry.

Decomposition:
- Package seq_alu_pkg:
  - opcode localparams OP_MULT=1, OP_ADD=2, OP_SLLI=3, OP_XOR=4, OP_BEQ=5, OP_SUB=6, OP_BGE=7, OP_MULHU=8
  - state enum {IDLE, MUL_BUSY, DONE}
- Sub-module seq_alu_mul_iter holds the shift-add engine. Interface: start, a, b, busy, done, prod. Parameterised by WIDTH; the top FSM sequences it.

Test Plan (WIDTH=32):
- Reset: assert rst_n=0 at iteration 10 of mult 5×7. Required: next cycle state IDLE, out_valid=0, result=0, in_ready=1; a following add 1+1 returns 2.
- add 0xFFFF_FFFF+1 → result 0x0, zero 0, out_valid exactly 1 cycle after accept. sub 3-5 → 0xFFFF_FFFE.
- mult 0x0001_0000×0x0001_0000:
  - result 0x0; out_valid exactly 33 cycles after the accept edge; in_ready=0 for cycles 1–32.
  - mult 0xFFFF_FFFF×2 → 0xFFFF_FFFE.
  - With SEQ_ALU_MULH_EN, mulhu 0x0001_0000×0x0001_0000 → 0x1; without it, opcode 8 → 0 after 1 cycle.
- Backpressure: add 5+6, out_ready=0 for 5 cycles. Required: result stays 11, out_valid stays 1, in_ready stays 0. Then out_ready=1 with xor 0xF0^0xFF presented: both handshakes fire on that edge, and the next cycle shows 0x0F.
- Branch/shift:
  - bge 3,5 → zero 0; bge 5,5 → 1; bge 0xFFFF_FFFF,1 → 1 (unsigned)
  - beq 7,7 → 1; beq 7,8 → 0
  - slli A=1,B=31 → 0x8000_0000; A=1,B=33 → 0x2
  - opcode 15 → result 0, zero 0
